// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB-lite arbiter: grants the shared address/data path to M0 or M1,
// muxes the address phase by hmaster and write data by the data-phase owner.
module ahb_arbiter_2m #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter bit DEFAULT_MASTER = 1'b0,
    parameter bit FIXED_PRIO     = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_busreq,
    input  logic          m0_lock,
    input  logic [1:0]    m0_htrans,
    input  logic [AW-1:0] m0_haddr,
    input  logic [7:0]    m0_hctrl,
    input  logic [DW-1:0] m0_hwdata,
    input  logic          m1_busreq,
    input  logic          m1_lock,
    input  logic [1:0]    m1_htrans,
    input  logic [AW-1:0] m1_haddr,
    input  logic [7:0]    m1_hctrl,
    input  logic [DW-1:0] m1_hwdata,
    input  logic          hready,
    input  logic          hresp,
    output logic          m0_hgrant,
    output logic          m1_hgrant,
    output logic [1:0]    htrans,
    output logic [AW-1:0] haddr,
    output logic [7:0]    hctrl,
    output logic [DW-1:0] hwdata,
    output logic          hmaster,
    output logic          hmaster_data,
    output logic          hmastlock
);

    logic grant_q, grant_d;
    logic hmaster_q, hmaster_d;
    logic hmaster_data_q, hmaster_data_d;
    logic hmastlock_q, hmastlock_d;
    logic last_q, last_d;

    logic       owner_lock;
    logic [1:0] addr_htrans;
    logic       hold;
    logic       next_grant;

    // hready is the transfer-accept strobe: every register advances only on an
    // edge where hready=1; an hready=0 edge is a wait state and freezes them.
    always_comb begin
        owner_lock  = grant_q ? m1_lock : m0_lock;
        addr_htrans = hmaster_q ? m1_htrans : m0_htrans;
        // BUSY (01) and SEQ (11) both have bit 0 set; they pin the grant.
        hold = owner_lock | hresp | ((hmaster_q == grant_q) & addr_htrans[0]);

        case ({m1_busreq, m0_busreq})
            2'b01:   next_grant = 1'b0;
            2'b10:   next_grant = 1'b1;
            2'b11:   next_grant = FIXED_PRIO ? 1'b1 : ~last_q;
            default: next_grant = DEFAULT_MASTER;
        endcase
        if (hold) begin
            next_grant = grant_q;
        end

        grant_d        = grant_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        hmastlock_d    = hmastlock_q;
        last_d         = last_q;
        if (hready) begin
            hmaster_data_d = hmaster_q;
            hmaster_d      = grant_q;
            hmastlock_d    = owner_lock;
            grant_d        = next_grant;
            last_d         = hmaster_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q        <= DEFAULT_MASTER;
            hmaster_q      <= DEFAULT_MASTER;
            hmaster_data_q <= DEFAULT_MASTER;
            hmastlock_q    <= 1'b0;
            last_q         <= DEFAULT_MASTER;
        end else begin
            grant_q        <= grant_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            hmastlock_q    <= hmastlock_d;
            last_q         <= last_d;
        end
    end

    assign m0_hgrant    = ~grant_q;
    assign m1_hgrant    = grant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign hmastlock    = hmastlock_q;

    // Reset kills any address phase in flight, so the interconnect sees IDLE.
    assign htrans = reset ? 2'b00 : addr_htrans;
    assign haddr  = hmaster_q ? m1_haddr : m0_haddr;
    assign hctrl  = hmaster_q ? m1_hctrl : m0_hctrl;
    assign hwdata = hmaster_data_q ? m1_hwdata : m0_hwdata;

endmodule
